alu_sequencer: RTL and testbench

- Command-driven controller that sequences the 8-bit accumulator ALU.
- Accepts operation commands over a valid/ready interface and buffers them in a small FIFO.
- Issues each command to the ALU by driving its operand, input-select and output-select controls, waits the ALU pipeline latency, then captures the result and overflow into a response handshake.
- Sits between the host/test driver and the ALU; owns the run/error state tracking.

---
 rtl/alu_sequencer_pkg.sv | 74 +++++++
 rtl/alu_sequencer_fifo.sv | 91 +++++++++
 rtl/alu_sequencer.sv | 218 +++++++++++++++++++++
 tb/tb_alu_sequencer.sv | 392 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// alu_sequencer_pkg
// Shared definitions for the ALU command sequencer: FSM state encoding,
// ALU op codes, one-hot input/output select constants and the decode
// helpers that map a command onto the ALU select lines.
// -----------------------------------------------------------------------------
package alu_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_OFF   = 3'd0,
        ST_READY = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_RESP  = 3'd4,
        ST_ERROR = 3'd5
    } seq_state_e;

    typedef enum logic [2:0] {
        OP_AND  = 3'd0,
        OP_OR   = 3'd1,
        OP_NOT  = 3'd2,
        OP_XOR  = 3'd3,
        OP_ADD  = 3'd4,
        OP_SUB  = 3'd5,
        OP_MULT = 3'd6,
        OP_CLR  = 3'd7
    } alu_op_e;

    // ALU input select (one-hot)
    localparam logic [2:0] IN_SEL_PERSIST = 3'b001;
    localparam logic [2:0] IN_SEL_LOAD    = 3'b010;
    localparam logic [2:0] IN_SEL_RESET   = 3'b100;

    // ALU output select (one-hot)
    localparam logic [6:0] OUT_SEL_AND  = 7'b000_0001;
    localparam logic [6:0] OUT_SEL_OR   = 7'b000_0010;
    localparam logic [6:0] OUT_SEL_NOT  = 7'b000_0100;
    localparam logic [6:0] OUT_SEL_XOR  = 7'b000_1000;
    localparam logic [6:0] OUT_SEL_ADD  = 7'b001_0000;
    localparam logic [6:0] OUT_SEL_SUB  = 7'b010_0000;
    localparam logic [6:0] OUT_SEL_MULT = 7'b100_0000;

    // Op code -> one-hot output select. CLR has no output select of its
    // own; callers keep the previous selection for it.
    function automatic logic [6:0] op_to_out_sel(input logic [2:0] op);
        logic [6:0] sel;
        sel = '0;
        case (op)
            OP_AND:  sel = OUT_SEL_AND;
            OP_OR:   sel = OUT_SEL_OR;
            OP_NOT:  sel = OUT_SEL_NOT;
            OP_XOR:  sel = OUT_SEL_XOR;
            OP_ADD:  sel = OUT_SEL_ADD;
            OP_SUB:  sel = OUT_SEL_SUB;
            OP_MULT: sel = OUT_SEL_MULT;
            default: sel = '0;
        endcase
        return sel;
    endfunction

    // Op code + load flag -> one-hot input select for the issue cycle.
    function automatic logic [2:0] op_to_in_sel(input logic [2:0] op, input logic ld);
        logic [2:0] sel;
        if (op == OP_CLR) begin
            sel = IN_SEL_RESET;
        end else if (ld) begin
            sel = IN_SEL_LOAD;
        end else begin
            sel = IN_SEL_PERSIST;
        end
        return sel;
    endfunction

endpackage

// File: rtl/alu_sequencer_fifo.sv
// -----------------------------------------------------------------------------
// seq_cmd_fifo
// Synchronous command FIFO for the ALU sequencer. DEPTH entries of DW bits,
// asynchronous active-low reset, synchronous flush.
// Ports:
//   clk_i    clock, rising edge
//   rst_ni   asynchronous reset, active low
//   flush_i  empties the FIFO at the next edge (wins over push/pop)
//   push_i   write wdata_i (ignored when full, even if popping)
//   pop_i    discard the head entry (ignored when empty)
//   wdata_i  entry to write
//   rdata_o  current head entry
//   full_o   DEPTH entries held
//   empty_o  no entries held
// -----------------------------------------------------------------------------
module seq_cmd_fifo
    import alu_sequencer_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned DW    = 20
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          flush_i,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [DW-1:0] wdata_i,
    output logic [DW-1:0] rdata_o,
    output logic          full_o,
    output logic          empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          push_ok;
    logic          pop_ok;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Pointers are AW bits wide, so they wrap modulo DEPTH.
            if (push_ok) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            if (push_ok && !pop_ok) begin
                count_d = count_q + (AW+1)'(1);
            end else if (pop_ok && !push_ok) begin
                count_d = count_q - (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; occupancy is tracked by count_q alone.
    always_ff @(posedge clk_i) begin
        if (push_ok && !flush_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/alu_sequencer.sv
// -----------------------------------------------------------------------------
// alu_sequencer
// Command-driven controller for the 8-bit accumulator ALU. Commands are
// queued in a small FIFO, issued one at a time onto the ALU select/operand
// lines, and after the ALU pipeline latency the result is returned on a
// valid/ready response channel. A multiply overflow parks the block in
// ERROR until err_clr.
// Ports:
//   clk, rst            clock; asynchronous active-low reset
//   on                  enable; when low the block finishes the current
//                       command and drains to OFF
//   cmd_valid/ready     command handshake; cmd_op/ld/a/b carry the command
//   alu_num1/num2       operands to the ALU
//   alu_in_sel          one-hot accumulator control (persist/load/reset)
//   alu_out_sel         one-hot result select (AND..MULT)
//   alu_result/ovf      ALU result and multiply overflow
//   res_valid/ready     response handshake; res_data/res_err carry it
//   err_clr             pulse to leave ERROR
//   state               current FSM state encoding
//   done_cnt            completed responses, wraps modulo 256
// -----------------------------------------------------------------------------
module alu_sequencer
    import alu_sequencer_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned LAT   = 1,
    parameter int unsigned W     = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         on,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [2:0]   cmd_op,
    input  logic         cmd_ld,
    input  logic [W-1:0] cmd_a,
    input  logic [W-1:0] cmd_b,
    output logic [W-1:0] alu_num1,
    output logic [W-1:0] alu_num2,
    output logic [2:0]   alu_in_sel,
    output logic [6:0]   alu_out_sel,
    input  logic [W-1:0] alu_result,
    input  logic         alu_ovf,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [W-1:0] res_data,
    output logic         res_err,
    input  logic         err_clr,
    output logic [2:0]   state,
    output logic [7:0]   done_cnt
);

    localparam int unsigned DW = 3 + 1 + 2 * W;
    localparam int unsigned CW = (LAT < 2) ? 1 : $clog2(LAT + 1);

    seq_state_e     state_q, state_d;
    alu_op_e        op_q, op_d;
    logic [W-1:0]   num1_q, num1_d;
    logic [W-1:0]   num2_q, num2_d;
    logic [2:0]     in_sel_q, in_sel_d;
    logic [6:0]     out_sel_q, out_sel_d;
    logic [W-1:0]   res_data_q, res_data_d;
    logic           res_err_q, res_err_d;
    logic [7:0]     done_q, done_d;
    logic [CW-1:0]  cnt_q, cnt_d;

    logic           fifo_push;
    logic           fifo_pop;
    logic           fifo_flush;
    logic           fifo_full;
    logic           fifo_empty;
    logic [DW-1:0]  fifo_wdata;
    logic [DW-1:0]  fifo_rdata;
    logic [2:0]     head_op;
    logic           head_ld;
    logic [W-1:0]   head_a;
    logic [W-1:0]   head_b;

    assign cmd_ready  = !fifo_full && (state_q != ST_OFF);
    assign fifo_push  = cmd_valid && cmd_ready;
    // The head is captured into the ALU registers on entry to ISSUE and
    // retired during ISSUE, so it never has to be held past that cycle.
    assign fifo_pop   = (state_q == ST_ISSUE);
    // Flushing on every transition into (and while in) OFF discards
    // anything left queued when the block is switched off.
    assign fifo_flush = (state_d == ST_OFF);
    assign fifo_wdata = {cmd_op, cmd_ld, cmd_a, cmd_b};
    assign {head_op, head_ld, head_a, head_b} = fifo_rdata;

    seq_cmd_fifo #(
        .DEPTH (DEPTH),
        .DW    (DW)
    ) u_fifo (
        .clk_i   (clk),
        .rst_ni  (rst),
        .flush_i (fifo_flush),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .wdata_i (fifo_wdata),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        num1_d     = num1_q;
        num2_d     = num2_q;
        in_sel_d   = in_sel_q;
        out_sel_d  = out_sel_q;
        res_data_d = res_data_q;
        res_err_d  = res_err_q;
        done_d     = done_q;
        cnt_d      = cnt_q;

        case (state_q)
            ST_OFF: begin
                if (on) begin
                    state_d = ST_READY;
                end
            end

            ST_READY: begin
                if (!on) begin
                    state_d = ST_OFF;
                end else if (!fifo_empty) begin
                    state_d  = ST_ISSUE;
                    op_d     = alu_op_e'(head_op);
                    num1_d   = head_a;
                    num2_d   = head_b;
                    in_sel_d = op_to_in_sel(head_op, head_ld);
                    if (head_op != OP_CLR) begin
                        out_sel_d = op_to_out_sel(head_op);
                    end
                end
            end

            ST_ISSUE: begin
                state_d  = ST_WAIT;
                in_sel_d = IN_SEL_PERSIST;
                cnt_d    = CW'(LAT);
            end

            ST_WAIT: begin
                if (cnt_q <= CW'(1)) begin
                    state_d    = ST_RESP;
                    res_data_d = (op_q == OP_CLR) ? '0 : alu_result;
                    res_err_d  = (op_q == OP_MULT) && alu_ovf;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end

            ST_RESP: begin
                if (res_ready) begin
                    done_d = done_q + 8'd1;
                    if (res_err_q) begin
                        state_d = ST_ERROR;
                    end else if (!on) begin
                        state_d = ST_OFF;
                    end else begin
                        state_d = ST_READY;
                    end
                end
            end

            ST_ERROR: begin
                if (!on) begin
                    state_d = ST_OFF;
                end else if (err_clr) begin
                    state_d = ST_READY;
                end
            end

            default: begin
                state_d = ST_OFF;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_OFF;
            op_q       <= OP_AND;
            num1_q     <= '0;
            num2_q     <= '0;
            in_sel_q   <= IN_SEL_PERSIST;
            out_sel_q  <= OUT_SEL_AND;
            res_data_q <= '0;
            res_err_q  <= 1'b0;
            done_q     <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            num1_q     <= num1_d;
            num2_q     <= num2_d;
            in_sel_q   <= in_sel_d;
            out_sel_q  <= out_sel_d;
            res_data_q <= res_data_d;
            res_err_q  <= res_err_d;
            done_q     <= done_d;
            cnt_q      <= cnt_d;
        end
    end

    assign alu_num1    = num1_q;
    assign alu_num2    = num2_q;
    assign alu_in_sel  = in_sel_q;
    assign alu_out_sel = out_sel_q;
    assign res_valid   = (state_q == ST_RESP);
    assign res_data    = res_data_q;
    assign res_err     = res_err_q;
    assign state       = state_q;
    assign done_cnt    = done_q;

endmodule

// File: tb/tb_alu_sequencer.sv
module tb_alu_sequencer;

    logic       clk;
    logic       rst;
    logic       on;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic       cmd_ld;
    logic [7:0] cmd_a;
    logic [7:0] cmd_b;
    logic [7:0] alu_num1;
    logic [7:0] alu_num2;
    logic [2:0] alu_in_sel;
    logic [6:0] alu_out_sel;
    logic [7:0] alu_result;
    logic       alu_ovf;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] res_data;
    logic       res_err;
    logic       err_clr;
    logic [2:0] state;
    logic [7:0] done_cnt;

    int checks = 0;
    int passes = 0;

    alu_sequencer #(
        .DEPTH (4),
        .LAT   (1),
        .W     (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .on          (on),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_ld      (cmd_ld),
        .cmd_a       (cmd_a),
        .cmd_b       (cmd_b),
        .alu_num1    (alu_num1),
        .alu_num2    (alu_num2),
        .alu_in_sel  (alu_in_sel),
        .alu_out_sel (alu_out_sel),
        .alu_result  (alu_result),
        .alu_ovf     (alu_ovf),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_data    (res_data),
        .res_err     (res_err),
        .err_clr     (err_clr),
        .state       (state),
        .done_cnt    (done_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Accumulator ALU model: registers its inputs on the issue cycle and
    // presents the result one cycle later; the result becomes the new
    // accumulator value.
    logic [7:0]  acc;
    logic [7:0]  alu_res_r;
    logic        alu_ovf_r;
    logic [7:0]  alu_opa;
    logic [15:0] alu_full;

    always_comb begin
        alu_opa  = alu_in_sel[2] ? 8'd0 : (alu_in_sel[1] ? alu_num1 : acc);
        alu_full = 16'd0;
        case (alu_out_sel)
            7'b000_0001: alu_full = {8'd0, alu_opa & alu_num2};
            7'b000_0010: alu_full = {8'd0, alu_opa | alu_num2};
            7'b000_0100: alu_full = {8'd0, ~alu_opa};
            7'b000_1000: alu_full = {8'd0, alu_opa ^ alu_num2};
            7'b001_0000: alu_full = {8'd0, alu_opa + alu_num2};
            7'b010_0000: alu_full = {8'd0, alu_opa - alu_num2};
            7'b100_0000: alu_full = {8'd0, alu_opa} * {8'd0, alu_num2};
            default:     alu_full = 16'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc       <= 8'd0;
            alu_res_r <= 8'd0;
            alu_ovf_r <= 1'b0;
        end else if (state == 3'd2) begin
            acc       <= alu_in_sel[2] ? 8'd0 : alu_full[7:0];
            alu_res_r <= alu_full[7:0];
            alu_ovf_r <= (alu_out_sel == 7'b100_0000) && (alu_full[15:8] != 8'd0);
        end
    end

    assign alu_result = alu_res_r;
    assign alu_ovf    = alu_ovf_r;

    task automatic push_cmd(input logic [2:0] op, input logic ld, input logic [7:0] a,
                            input logic [7:0] b, output bit ok);
        int n;
        n = 0;
        cmd_op    = op;
        cmd_ld    = ld;
        cmd_a     = a;
        cmd_b     = b;
        cmd_valid = 1'b1;
        while (!cmd_ready && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        ok = cmd_ready;
        if (ok) begin
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
    endtask

    task automatic wait_resp(output bit ok);
        int n;
        n = 0;
        while (!res_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        ok = res_valid;
    endtask

    task automatic wait_state(input logic [2:0] s, output bit ok);
        int n;
        n = 0;
        while (state !== s && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        ok = (state === s);
    endtask

    task automatic test_reset();
        rst = 1'b0; on = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_ld = 1'b0;
        cmd_a = '0; cmd_b = '0; res_ready = 1'b1; err_clr = 1'b0;
        #12;
        checks++;
        if ({state, cmd_ready, res_valid, res_err} !== {3'd0, 1'b0, 1'b0, 1'b0})
            $display("FAIL reset_ctrl: got %b expected %b", {state, cmd_ready, res_valid, res_err}, 6'b000000);
        else passes++;
        checks++;
        if ({res_data, done_cnt} !== 16'd0)
            $display("FAIL reset_data: got %h expected 0000", {res_data, done_cnt});
        else passes++;
        checks++;
        if ({alu_num1, alu_num2, alu_in_sel, alu_out_sel} !== {8'd0, 8'd0, 3'b001, 7'b000_0001})
            $display("FAIL reset_alu: got %h/%h/%b/%b expected 0/0/001/0000001",
                     alu_num1, alu_num2, alu_in_sel, alu_out_sel);
        else passes++;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (state !== 3'd0) $display("FAIL off_hold: state got %0d expected 0", state);
        else passes++;
    endtask

    task automatic test_basic();
        bit ok;
        on = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({state, cmd_ready} !== {3'd1, 1'b1})
            $display("FAIL basic_ready: state/cmd_ready got %0d/%b expected 1/1", state, cmd_ready);
        else passes++;
        push_cmd(3'd4, 1'b1, 8'd5, 8'd3, ok);
        checks++;
        if (ok !== 1'b1) $display("FAIL basic_push: accepted got %b expected 1", ok);
        else passes++;
        @(posedge clk); #1;
        checks++;
        if ({state, alu_in_sel, alu_num1, alu_num2, alu_out_sel} !== {3'd2, 3'b010, 8'd5, 8'd3, 7'b001_0000})
            $display("FAIL basic_issue: got %0d/%b/%0d/%0d/%b expected 2/010/5/3/0010000",
                     state, alu_in_sel, alu_num1, alu_num2, alu_out_sel);
        else passes++;
        @(posedge clk); #1;
        checks++;
        if ({state, alu_in_sel} !== {3'd3, 3'b001})
            $display("FAIL basic_wait: state/in_sel got %0d/%b expected 3/001", state, alu_in_sel);
        else passes++;
        wait_resp(ok);
        checks++;
        if ({ok, res_data, res_err} !== {1'b1, 8'd8, 1'b0})
            $display("FAIL basic_resp: valid/data/err got %b/%0d/%b expected 1/8/0", ok, res_data, res_err);
        else passes++;
        @(posedge clk); #1;
        checks++;
        if ({done_cnt, res_valid} !== {8'd1, 1'b0})
            $display("FAIL basic_done: done_cnt/res_valid got %0d/%b expected 1/0", done_cnt, res_valid);
        else passes++;
    endtask

    task automatic test_chain();
        logic [2:0] ops     [3] = '{3'd4, 3'd5, 3'd7};
        logic       lds     [3] = '{1'b1, 1'b0, 1'b0};
        logic [7:0] as      [3] = '{8'd10, 8'd99, 8'd0};
        logic [7:0] bs      [3] = '{8'd2, 8'd4, 8'd0};
        logic [2:0] exp_in  [3] = '{3'b010, 3'b001, 3'b100};
        logic [6:0] exp_out [3] = '{7'b001_0000, 7'b010_0000, 7'b010_0000};
        logic [7:0] exp_dat [3] = '{8'd12, 8'd8, 8'd0};
        bit ok;
        for (int i = 0; i < 3; i++) begin
            push_cmd(ops[i], lds[i], as[i], bs[i], ok);
            wait_state(3'd2, ok);
            checks++;
            if ({ok, alu_in_sel, alu_out_sel} !== {1'b1, exp_in[i], exp_out[i]})
                $display("FAIL chain_issue%0d: issued/in_sel/out_sel got %b/%b/%b expected 1/%b/%b",
                         i, ok, alu_in_sel, alu_out_sel, exp_in[i], exp_out[i]);
            else passes++;
            wait_resp(ok);
            checks++;
            if ({ok, res_data, res_err} !== {1'b1, exp_dat[i], 1'b0})
                $display("FAIL chain_resp%0d: valid/data/err got %b/%0d/%b expected 1/%0d/0",
                         i, ok, res_data, res_err, exp_dat[i]);
            else passes++;
            @(posedge clk); #1;
        end
        checks++;
        if (done_cnt !== 8'd4) $display("FAIL chain_done: done_cnt got %0d expected 4", done_cnt);
        else passes++;
    endtask

    task automatic test_overflow();
        bit ok;
        push_cmd(3'd6, 1'b1, 8'd200, 8'd2, ok);
        wait_resp(ok);
        checks++;
        if ({ok, res_data, res_err} !== {1'b1, 8'd144, 1'b1})
            $display("FAIL ovf_resp: valid/data/err got %b/%0d/%b expected 1/144/1", ok, res_data, res_err);
        else passes++;
        @(posedge clk); #1;
        checks++;
        if ({state, res_valid} !== {3'd5, 1'b0})
            $display("FAIL ovf_error: state/res_valid got %0d/%b expected 5/0", state, res_valid);
        else passes++;
        push_cmd(3'd4, 1'b0, 8'd0, 8'd1, ok);
        checks++;
        if (ok !== 1'b1) $display("FAIL ovf_push: accepted in ERROR got %b expected 1", ok);
        else passes++;
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if ({state, res_valid, alu_in_sel} !== {3'd5, 1'b0, 3'b001})
            $display("FAIL ovf_hold: state/res_valid/in_sel got %0d/%b/%b expected 5/0/001",
                     state, res_valid, alu_in_sel);
        else passes++;
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        checks++;
        if (state !== 3'd1) $display("FAIL ovf_clr: state got %0d expected 1", state);
        else passes++;
        wait_resp(ok);
        checks++;
        if ({ok, res_data, res_err} !== {1'b1, 8'd145, 1'b0})
            $display("FAIL ovf_queued: valid/data/err got %b/%0d/%b expected 1/145/0", ok, res_data, res_err);
        else passes++;
        @(posedge clk); #1;
        checks++;
        if ({state, done_cnt} !== {3'd1, 8'd6})
            $display("FAIL ovf_done: state/done_cnt got %0d/%0d expected 1/6", state, done_cnt);
        else passes++;
    endtask

    task automatic test_back_to_back();
        bit ok;
        bit all_ok;
        res_ready = 1'b0;
        all_ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            push_cmd(3'd4, (i == 0), 8'd1, 8'd1, ok);
            all_ok = all_ok & ok;
        end
        checks++;
        if (all_ok !== 1'b1) $display("FAIL b2b_push: five accepted got %b expected 1", all_ok);
        else passes++;
        checks++;
        if ({cmd_ready, state, res_data} !== {1'b0, 3'd4, 8'd2})
            $display("FAIL b2b_full: cmd_ready/state/data got %b/%0d/%0d expected 0/4/2",
                     cmd_ready, state, res_data);
        else passes++;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({res_valid, res_data, cmd_ready} !== {1'b1, 8'd2, 1'b0})
            $display("FAIL b2b_stable: valid/data/cmd_ready got %b/%0d/%b expected 1/2/0",
                     res_valid, res_data, cmd_ready);
        else passes++;
        res_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wait_resp(ok);
            checks++;
            if ({ok, res_data} !== {1'b1, 8'(2 + i)})
                $display("FAIL b2b_drain%0d: valid/data got %b/%0d expected 1/%0d", i, ok, res_data, 2 + i);
            else passes++;
            @(posedge clk); #1;
        end
        checks++;
        if (done_cnt !== 8'd11) $display("FAIL b2b_done: done_cnt got %0d expected 11", done_cnt);
        else passes++;
    endtask

    task automatic test_on_drop();
        bit ok;
        bit all_ok;
        all_ok = 1'b1;
        push_cmd(3'd4, 1'b1, 8'd20, 8'd1, ok);
        all_ok = all_ok & ok;
        push_cmd(3'd4, 1'b0, 8'd0, 8'd1, ok);
        all_ok = all_ok & ok;
        push_cmd(3'd4, 1'b0, 8'd0, 8'd1, ok);
        all_ok = all_ok & ok;
        wait_state(3'd3, ok);
        checks++;
        if ({all_ok, ok} !== 2'b11) $display("FAIL drop_setup: pushed/in_wait got %b/%b expected 1/1", all_ok, ok);
        else passes++;
        on = 1'b0;
        wait_resp(ok);
        checks++;
        if ({ok, res_data} !== {1'b1, 8'd21})
            $display("FAIL drop_resp: valid/data got %b/%0d expected 1/21", ok, res_data);
        else passes++;
        @(posedge clk); #1;
        checks++;
        if ({state, cmd_ready, res_valid} !== {3'd0, 1'b0, 1'b0})
            $display("FAIL drop_off: state/cmd_ready/res_valid got %0d/%b/%b expected 0/0/0",
                     state, cmd_ready, res_valid);
        else passes++;
        on = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if ({state, done_cnt} !== {3'd1, 8'd12})
            $display("FAIL drop_flushed: state/done_cnt got %0d/%0d expected 1/12", state, done_cnt);
        else passes++;
    endtask

    task automatic test_async_reset();
        bit ok;
        res_ready = 1'b0;
        push_cmd(3'd4, 1'b1, 8'd7, 8'd7, ok);
        wait_resp(ok);
        checks++;
        if ({ok, res_data} !== {1'b1, 8'd14})
            $display("FAIL arst_pre: valid/data got %b/%0d expected 1/14", ok, res_data);
        else passes++;
        #3;
        rst = 1'b0;
        #1;
        checks++;
        if ({state, cmd_ready, res_valid, res_err, res_data, done_cnt} !== {3'd0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0})
            $display("FAIL arst_ctrl: state/rdy/valid/err/data/done got %0d/%b/%b/%b/%0d/%0d expected 0/0/0/0/0/0",
                     state, cmd_ready, res_valid, res_err, res_data, done_cnt);
        else passes++;
        checks++;
        if ({alu_num1, alu_num2, alu_in_sel, alu_out_sel} !== {8'd0, 8'd0, 3'b001, 7'b000_0001})
            $display("FAIL arst_alu: got %0d/%0d/%b/%b expected 0/0/001/0000001",
                     alu_num1, alu_num2, alu_in_sel, alu_out_sel);
        else passes++;
        res_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_chain();
        test_overflow();
        test_back_to_back();
        test_on_drop();
        test_async_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d passed", passes, checks);
        $fatal(1, "watchdog");
    end

endmodule
